// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display controller: FSM states,
// BCD accumulator size, active-low glyphs (bit6=a .. bit0=g) and the add-3 step.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ABS    = 2'd1,
      CONV   = 2'd2,
      UPDATE = 2'd3
   } state_t;

   localparam int BCD_DIGITS = 10;
   localparam int BCD_W      = 4 * BCD_DIGITS;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0001100;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_MINUS = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
   function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int n = 0; n < BCD_DIGITS; n++) begin
         if (bcd[4*n +: 4] >= 4'd5)
            res[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
      end
      return res;
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to active-low seven-segment glyph; non-decimal
// codes render as 'E'.
module seg7_encode
   import display_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_E;
      case (i_digit)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_E;
      endcase
   end

endmodule

// File: rtl/display_update_ctrl.sv
// Signed 32-bit value to eight seven-segment displays via a 32-cycle double-dabble.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module display_update_ctrl
   import display_pkg::*;
#(
   parameter int DIGITS = 7,
   parameter int ITER   = 32
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        upd_valid,
   input  logic [31:0] upd_data,
   output logic        upd_ready,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5,
   output logic [6:0]  HEX6,
   output logic [6:0]  HEX7
);

   localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

   state_t           r_state;
   logic [31:0]      r_data;
   logic [31:0]      r_mag;
   logic [BCD_W-1:0] r_bcd;
   logic [4:0]       r_cnt;
   logic             r_neg;
   logic             r_nz;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;
   logic             r_ovf;
   logic [6:0]       r_sign;

   logic             w_ovf;
   logic [6:0]       w_hex [0:6];

   // Digits above the displayable range must all be zero for the value to fit.
   always_comb begin
      w_ovf = 1'b0;
      for (int n = DIGITS; n < BCD_DIGITS; n++)
         w_ovf = w_ovf | (r_bcd[4*n +: 4] != 4'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_mag   <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_neg   <= 1'b0;
         r_nz    <= 1'b0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
         r_sign  <= SEG_BLANK;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (upd_valid && r_ready) begin
                  r_data  <= upd_data;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ABS;
               end
            end
            ABS: begin
               r_mag   <= r_data[31] ? (~r_data + 32'd1) : r_data;
               r_neg   <= r_data[31];
               r_nz    <= |r_data;
               r_bcd   <= '0;
               r_cnt   <= '0;
               r_state <= CONV;
            end
            CONV: begin
               {r_bcd, r_mag} <= {bcd_add3(r_bcd), r_mag} << 1;
               r_cnt          <= r_cnt + 5'd1;
               if (r_cnt == LAST_ITER)
                  r_state <= UPDATE;
            end
            UPDATE: begin
               r_ovf   <= w_ovf;
               r_sign  <= (r_neg && r_nz) ? SEG_MINUS : SEG_BLANK;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // w_zero_from[i]: BCD nibbles i..DIGITS-1 are all zero.
   logic [DIGITS:1] w_zero_from;

   for (genvar gi = 1; gi <= DIGITS; gi++) begin : g_lz
      if (gi == DIGITS) begin : g_top
         assign w_zero_from[gi] = 1'b1;
      end else begin : g_chain
         assign w_zero_from[gi] = (r_bcd[4*gi +: 4] == 4'd0) && w_zero_from[gi+1];
      end
   end
`endif

   for (genvar gi = 0; gi < 7; gi++) begin : g_digit
      if (gi < DIGITS) begin : g_used
         logic [6:0] w_glyph;
         logic [6:0] w_next;
         logic [6:0] r_seg;

         seg7_encode u_enc (
            .i_digit (r_bcd[4*gi +: 4]),
            .o_seg   (w_glyph)
         );

`ifdef LEADING_ZERO_BLANK_EN
         if (gi == 0) begin : g_lsd
            assign w_next = w_ovf ? SEG_E : w_glyph;
         end else begin : g_msd
            assign w_next = w_ovf ? SEG_E :
                            (w_zero_from[gi] ? SEG_BLANK : w_glyph);
         end
`else
         assign w_next = w_ovf ? SEG_E : w_glyph;
`endif

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_seg <= SEG_0;
            else if (r_state == UPDATE)
               r_seg <= w_next;
         end

         assign w_hex[gi] = r_seg;
      end else begin : g_unused
         assign w_hex[gi] = SEG_BLANK;
      end
   end

   assign upd_ready = r_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign ovf       = r_ovf;
   assign HEX0      = w_hex[0];
   assign HEX1      = w_hex[1];
   assign HEX2      = w_hex[2];
   assign HEX3      = w_hex[3];
   assign HEX4      = w_hex[4];
   assign HEX5      = w_hex[5];
   assign HEX6      = w_hex[6];
   assign HEX7      = r_sign;

endmodule

// File: tb/tb_display_update_ctrl.sv
// Directed, table-driven bench for display_update_ctrl (DIGITS=7), with
// hand-written back-to-back and reset-mid-conversion sequences.
module tb_display_update_ctrl;

   localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
   localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100;
   localparam logic [6:0] G6 = 7'b0100000, G7 = 7'b0001111, G8 = 7'b0000000;
   localparam logic [6:0] G9 = 7'b0001100, GE = 7'b0110000;
   localparam logic [6:0] MN = 7'b1111110, BL = 7'b1111111;
   localparam logic [55:0] RST_HEX = {BL, G0, G0, G0, G0, G0, G0, G0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_data = '0;
   logic        upd_ready, busy, done, ovf;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string          name;
      logic [31:0]    val;
      logic [55:0]    hex;   // {HEX7, HEX6, ..., HEX0}
      logic           ovf;
   } vec_t;

   vec_t vecs [9];

   display_update_ctrl #(.DIGITS(7)) dut (
      .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_data(upd_data),
      .upd_ready(upd_ready), .busy(busy), .done(done), .ovf(ovf),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
      .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
   );

   always #5 clk = ~clk;

   function automatic logic [55:0] hex_all();
      return {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
   endfunction

   // Expected-value adjustment for the leading-zero-blanking build.
   function automatic logic [55:0] exp_hex(input logic [55:0] e, input logic o);
      logic [55:0] r;
      r = e;
`ifdef LEADING_ZERO_BLANK_EN
      if (!o) begin
         for (int i = 6; i >= 1; i--) begin
            if (r[7*i +: 7] != G0) break;
            r[7*i +: 7] = BL;
         end
      end
`endif
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic        ok;
      logic [55:0] prev;
      logic [55:0] want;
      want = exp_hex(v.hex, v.ovf);
      prev = hex_all();
      upd_data  = v.val;
      upd_valid = 1'b1;
      @(negedge clk);
      upd_valid = 1'b0;
      upd_data  = 32'h1234_5678;
      check({v.name, "_accept"}, {busy, upd_ready}, 2'b10);
      ok = 1'b1;
      for (int j = 1; j <= 33; j++) begin
         @(negedge clk);
         if (busy !== 1'b1 || done !== 1'b0 || upd_ready !== 1'b0 || hex_all() !== prev)
            ok = 1'b0;
      end
      check({v.name, "_busy_window"}, ok, 1'b1);
      @(negedge clk);
      check({v.name, "_done"}, {done, upd_ready, busy}, 3'b110);
      check({v.name, "_hex"}, hex_all(), want);
      check({v.name, "_ovf"}, ovf, v.ovf);
      @(negedge clk);
      check({v.name, "_done_pulse"}, done, 1'b0);
      $display("vec %s val=%0d hex=%h ovf=%b", v.name, $signed(v.val), hex_all(), ovf);
   endtask

   initial begin
      logic ok;

      vecs[0] = '{"pos12345",  32'd12345,     {BL, G0, G0, G1, G2, G3, G4, G5}, 1'b0};
      vecs[1] = '{"neg42",     32'hFFFF_FFD6, {MN, G0, G0, G0, G0, G0, G4, G2}, 1'b0};
      vecs[2] = '{"zero",      32'd0,         {BL, G0, G0, G0, G0, G0, G0, G0}, 1'b0};
      vecs[3] = '{"ovf1e7",    32'd10000000,  {BL, GE, GE, GE, GE, GE, GE, GE}, 1'b1};
      vecs[4] = '{"minint",    32'h8000_0000, {MN, GE, GE, GE, GE, GE, GE, GE}, 1'b1};
      vecs[5] = '{"max7",      32'd9999999,   {BL, G9, G9, G9, G9, G9, G9, G9}, 1'b0};
      vecs[6] = '{"neg1",      32'hFFFF_FFFF, {MN, G0, G0, G0, G0, G0, G0, G1}, 1'b0};
      vecs[7] = '{"d8765432",  32'd8765432,   {BL, G8, G7, G6, G5, G4, G3, G2}, 1'b0};
      vecs[8] = '{"maxint",    32'h7FFF_FFFF, {BL, GE, GE, GE, GE, GE, GE, GE}, 1'b1};

      // Reset state, during and after reset
      repeat (3) @(negedge clk);
      check("rst_hex", hex_all(), RST_HEX);
      check("rst_ctl", {upd_ready, busy, done, ovf}, 4'b1000);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_hex", hex_all(), RST_HEX);
      check("post_rst_ctl", {upd_ready, busy, done, ovf}, 4'b1000);
      $display("reset hex=%h ready=%b", hex_all(), upd_ready);

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Back-to-back: 7 held, then 9 while busy; 9 must wait for upd_ready.
      upd_data  = 32'd7;
      upd_valid = 1'b1;
      @(negedge clk);
      upd_data = 32'd9;
      check("b2b_first_accept", {busy, upd_ready}, 2'b10);
      ok = 1'b1;
      for (int j = 1; j <= 33; j++) begin
         @(negedge clk);
         if (busy !== 1'b1 || upd_ready !== 1'b0 || done !== 1'b0) ok = 1'b0;
      end
      check("b2b_no_accept_busy", ok, 1'b1);
      @(negedge clk);
      check("b2b_hex7", hex_all(), exp_hex({BL, G0, G0, G0, G0, G0, G0, G7}, 1'b0));
      check("b2b_done7", {done, upd_ready}, 2'b11);
      @(negedge clk);
      upd_valid = 1'b0;
      check("b2b_second_accept", {busy, upd_ready, done}, 3'b100);
      repeat (33) @(negedge clk);
      check("b2b_mid_hold7", hex_all(), exp_hex({BL, G0, G0, G0, G0, G0, G0, G7}, 1'b0));
      @(negedge clk);
      check("b2b_hex9", hex_all(), exp_hex({BL, G0, G0, G0, G0, G0, G0, G9}, 1'b0));
      check("b2b_done9", {done, upd_ready}, 2'b11);
      $display("b2b hex=%h", hex_all());
      @(negedge clk);

      // Reset ten cycles into a conversion of 999
      upd_data  = 32'd999;
      upd_valid = 1'b1;
      @(negedge clk);
      upd_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_hex", hex_all(), RST_HEX);
      check("midrst_ctl", {upd_ready, busy, done, ovf}, 4'b1000);
      @(negedge clk);
      rst = 1'b0;
      ok = 1'b1;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || upd_ready !== 1'b1 || hex_all() !== RST_HEX)
            ok = 1'b0;
      end
      check("midrst_quiet", ok, 1'b1);
      $display("midrst hex=%h ready=%b", hex_all(), upd_ready);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
